// File: rtl/offset_adder_pipe.sv
// offset_adder_pipe: adds one of two offsets to each operand through a DEPTH-stage valid/ready pipeline.
// Define OFFSET_ADDER_PIPE_SATURATE_EN to clamp overflowing results to all-ones instead of wrapping.
module offset_adder_pipe #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2,
    parameter logic [WIDTH:0] OFFSET_A = (WIDTH+1)'(7),
    parameter logic [WIDTH:0] OFFSET_B = (WIDTH+1)'(8)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_overflow,
    output logic             busy
);
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] o;
    logic [DEPTH-1:0] en;
    logic [WIDTH-1:0] d [DEPTH];
    logic [WIDTH+1:0] sum;
    logic             ovf;
    logic [WIDTH-1:0] res;
    assign sum = {2'b0, in_data} + {1'b0, in_mode ? OFFSET_B : OFFSET_A};
    assign ovf = |sum[WIDTH+1:WIDTH];
`ifdef OFFSET_ADDER_PIPE_SATURATE_EN
    assign res = ovf ? '1 : sum[WIDTH-1:0];
`else
    assign res = sum[WIDTH-1:0];
`endif
    // A stage may load unless it and every stage after it is full while the output stalls.
    for (genvar k = 0; k < DEPTH; k++) begin : g_en
        assign en[k] = out_ready || !(&v[DEPTH-1:k]);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v <= '0;
            o <= '0;
            for (int k = 0; k < DEPTH; k++) d[k] <= '0;
        end else begin
            if (en[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    d[0] <= res;
                    o[0] <= ovf;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (en[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        d[k] <= d[k-1];
                        o[k] <= o[k-1];
                    end
                end
            end
        end
    end
    assign in_ready     = !reset && en[0];
    assign out_valid    = v[DEPTH-1];
    assign out_data     = d[DEPTH-1];
    assign out_overflow = o[DEPTH-1];
    assign busy         = |v;
endmodule

// File: tb/tb_offset_adder_pipe.sv
// tb_offset_adder_pipe: random and directed stimulus against a queue-based model of offset_adder_pipe.
module tb_offset_adder_pipe;
    localparam int WIDTH = 3;
    localparam int DEPTH = 2;
    localparam int OFFA  = 7;
    localparam int OFFB  = 8;
    logic             clock = 0;
    logic             reset = 1;
    logic             in_valid = 0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_mode = 0;
    logic             out_valid;
    logic             out_ready = 1;
    logic [WIDTH-1:0] out_data;
    logic             out_overflow;
    logic             busy;
    int total = 0;
    int bad = 0;
    int nout = 0;
    int cyc = 0;
    int qd[$];
    int qo[$];
    int qc[$];
    int prev_stall = 0;
    int prev_d = 0;
    int prev_o = 0;

    offset_adder_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_overflow(out_overflow), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic void check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int model_data(int din, int mode);
        int s = din + (mode != 0 ? OFFB : OFFA);
`ifdef OFFSET_ADDER_PIPE_SATURATE_EN
        return s >= (1 << WIDTH) ? (1 << WIDTH) - 1 : s % (1 << WIDTH);
`else
        return s % (1 << WIDTH);
`endif
    endfunction

    function automatic int model_ovf(int din, int mode);
        return (din + (mode != 0 ? OFFB : OFFA)) >= (1 << WIDTH) ? 1 : 0;
    endfunction

    // Items live in the queue from acceptance until output; the head is presented DEPTH cycles after acceptance.
    always @(negedge clock) begin
        int n, exp_v;
        cyc++;
        if (reset) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_out_overflow", out_overflow, 0);
            check("rst_busy", busy, 0);
            check("rst_in_ready", in_ready, 0);
            qd.delete(); qo.delete(); qc.delete();
            prev_stall = 0;
        end else begin
            n = qd.size();
            exp_v = (n > 0 && cyc - qc[0] >= DEPTH) ? 1 : 0;
            check("out_valid", out_valid, exp_v);
            check("busy", busy, n > 0 ? 1 : 0);
            check("in_ready", in_ready, (out_ready || n < DEPTH) ? 1 : 0);
            if (exp_v != 0 && out_valid) begin
                check("out_data", out_data, qd[0]);
                check("out_overflow", out_overflow, qo[0]);
            end
            if (prev_stall != 0) begin
                check("stall_data_stable", out_data, prev_d);
                check("stall_ovf_stable", out_overflow, prev_o);
            end
            prev_stall = (out_valid && !out_ready) ? 1 : 0;
            prev_d = out_data;
            prev_o = out_overflow;
            if (exp_v != 0 && out_ready) begin
                void'(qd.pop_front()); void'(qo.pop_front()); void'(qc.pop_front());
                nout++;
            end
            if (in_valid && (out_ready || n < DEPTH)) begin
                qd.push_back(model_data(in_data, in_mode));
                qo.push_back(model_ovf(in_data, in_mode));
                qc.push_back(cyc);
            end
        end
    end

    task automatic send_one(input int din, input int mode, input int ed, input int eo);
        int k;
        out_ready = 1; in_valid = 1; in_data = WIDTH'(din); in_mode = mode[0];
        @(posedge clock); #1 in_valid = 0;
        k = 1;
        @(negedge clock);
        while (!out_valid && k < 10) begin
            k++;
            @(negedge clock);
        end
        check("lat", k, DEPTH);
        check("lit_data", out_data, ed);
        check("lit_ovf", out_overflow, eo);
        @(posedge clock); #1;
    endtask

    task automatic stream_test();
        int i = 0, c = 0, got_stall = 0, fire, start;
        start = nout;
        while (i < 8 && c < 60) begin
            in_valid = 1; in_data = WIDTH'(i); in_mode = 0;
            out_ready = !(c >= 3 && c <= 6);
            @(negedge clock);
            if (!in_ready) got_stall = 1;
            fire = in_ready;
            @(posedge clock); #1;
            if (fire != 0) i++;
            c++;
        end
        in_valid = 0; out_ready = 1;
        repeat (6) @(posedge clock);
        #1;
        check("stream_stalled", got_stall, 1);
        check("stream_count", nout - start, 8);
    endtask

    task automatic full_pass_test();
        out_ready = 0; in_valid = 1; in_data = 3; in_mode = 1;
        repeat (3) @(posedge clock);
        #1;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            in_data = WIDTH'(i);
            @(negedge clock);
            check("full_in_ready", in_ready, 1);
            check("full_busy", busy, 1);
            check("full_out_valid", out_valid, 1);
            @(posedge clock); #1;
        end
        in_valid = 0;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic async_reset_test();
        out_ready = 0; in_valid = 1; in_data = 6; in_mode = 0;
        repeat (3) @(posedge clock);
        #1 in_valid = 0;
        @(posedge clock); #2 reset = 1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 0);
        @(posedge clock); #2 reset = 0;
        out_ready = 1;
        @(negedge clock);
        check("arst_release_in_ready", in_ready, 1);
        repeat (4) @(posedge clock);
        #1;
        check("arst_no_stale", out_valid, 0);
    endtask

    initial begin
        #1;
        check("init_out_valid", out_valid, 0);
        check("init_in_ready", in_ready, 0);
        repeat (2) @(posedge clock);
        #1 reset = 0;
        @(posedge clock); #1;
        send_one(0, 0, 7, 0);
`ifdef OFFSET_ADDER_PIPE_SATURATE_EN
        send_one(2, 0, 7, 1);
        send_one(5, 1, 7, 1);
`else
        send_one(2, 0, 1, 1);
        send_one(5, 1, 5, 1);
`endif
        send_one(7, 1, model_data(7, 1), 1);
        stream_test();
        full_pass_test();
        async_reset_test();
        for (int i = 0; i < 500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = WIDTH'($urandom);
            in_mode   = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clock); #1;
        end
        in_valid = 0; out_ready = 1;
        repeat (6) @(posedge clock);
        #1;
        check("drain_busy", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/offset_adder_pipe.md
OFFSET_ADDER_PIPE -- requirements
Module: offset_adder_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, data width in bits (1..32).
REQ-002 The block SHALL have parameter DEPTH, default 2, number of pipeline stages (1..4).
REQ-003 The block SHALL have parameter OFFSET_A, default 7, unsigned WIDTH+1-bit offset selected by in_mode=0.
REQ-004 The block SHALL have parameter OFFSET_B, default 8, unsigned WIDTH+1-bit offset selected by in_mode=1.
REQ-005 The block SHALL have port clock, input, 1, sole clock; all state on rising edge.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1, upstream data valid.
REQ-008 The block SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-009 The block SHALL have port in_data, input, WIDTH, operand.
REQ-010 The block SHALL have port in_mode, input, 1, offset select.
REQ-011 The block SHALL have port out_valid, output, 1, out_data/out_overflow valid.
REQ-012 The block SHALL have port out_ready, input, 1, downstream accepts output.
REQ-013 The block SHALL have port out_data, output, WIDTH, result.
REQ-014 The block SHALL have port out_overflow, output, 1, result exceeded 2^WIDTH-1.
REQ-015 The block SHALL have port busy, output, 1, any stage holds valid data.

Function
REQ-016 Transfer in SHALL occur on a cycle with in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-017 Stage 0 SHALL compute sum = in_data + (in_mode ? OFFSET_B : OFFSET_A) at WIDTH+2 bits, unsigned, no truncation of the offset.
REQ-018 out_overflow SHALL be 1 iff sum >= 2^WIDTH; without SATURATE_EN, out_data SHALL be sum[WIDTH-1:0].
REQ-019 The pipeline SHALL be DEPTH registered stages, each holding valid bit, data, overflow; result of stage 0 SHALL be registered into stage 0.
REQ-020 Stage k SHALL advance when stage k+1 is empty or advancing; the last stage advances when out_ready.
REQ-021 in_ready SHALL be 1 when stage 0 is empty or advancing (combinational from out_ready and valid bits; bubbles collapse).
REQ-022 Unstalled latency SHALL be exactly DEPTH cycles from input transfer to out_valid=1; throughput one transfer per cycle.
REQ-023 While out_valid && !out_ready, out_data and out_overflow SHALL hold stable; no accepted data SHALL be lost or duplicated.
REQ-024 Simultaneous input and output transfer with a full pipeline SHALL be accepted (in_ready=1 when out_ready=1).
REQ-025 Input values SHALL be ignored when in_valid=0; in_data/in_mode need only be stable on transfer cycles.
REQ-026 busy SHALL be the OR of all stage valid bits; out_valid SHALL equal last-stage valid bit.

Reset
REQ-027 reset=1 SHALL asynchronously clear all stage valid bits, data and overflow to 0, independent of clock.
REQ-028 During reset out_valid=0, out_data=0, out_overflow=0, busy=0, in_ready=0.
REQ-029 Reset mid-operation SHALL discard all in-flight data; first cycle after deassertion in_ready=1.

Configuration
REQ-030 With macro OFFSET_ADDER_PIPE_SATURATE_EN defined, out_data SHALL be 2^WIDTH-1 when sum >= 2^WIDTH, else sum[WIDTH-1:0]; out_overflow unchanged.
REQ-031 Without OFFSET_ADDER_PIPE_SATURATE_EN, out_data SHALL wrap per REQ-018; no other behaviour differs.

Verification (WIDTH=3, DEPTH=2, defaults)
REQ-032 in_data=0, mode 0, out_ready=1 -> out_data=7, overflow=0, out_valid exactly 2 cycles after transfer.
REQ-033 in_data=2, mode 0 -> wrap build out_data=1, overflow=1; SATURATE_EN build out_data=7, overflow=1.
REQ-034 in_data=5, mode 1 -> wrap out_data=5, overflow=1 (13 mod 8); saturate out_data=7.
REQ-035 Stream 0..7 back-to-back, out_ready low cycles 3-6 -> in_ready drops after 2 words buffered, all 8 results in order, none lost/duplicated, out_data stable while stalled.
REQ-036 Full pipeline, in_valid=1 and out_ready=1 same cycle -> both transfers occur, busy stays 1, throughput 1/cycle.
REQ-037 Assert reset asynchronously mid-stream between clock edges -> outputs 0 immediately, no stale words after release, in_ready=1 next cycle.
